// File: rtl/vx_barrier_if.sv
// Barrier request/flush/release bundle between warp scheduler and barrier unit.
// master = scheduler side, slave = barrier unit.
interface vx_barrier_if #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4
);
  localparam int NW_WIDTH =
    (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NB_WIDTH =
    (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

  logic                 bar_valid;
  logic [NW_WIDTH-1:0]  bar_wid;
  logic [NB_WIDTH-1:0]  bar_id;
  logic [NW_WIDTH-1:0]  bar_size_m1;
  logic                 flush_valid;
  logic [NW_WIDTH-1:0]  flush_wid;
  logic [NUM_WARPS-1:0] stall_mask;
  logic                 release_valid;
  logic [NB_WIDTH-1:0]  release_id;
  logic [NUM_WARPS-1:0] release_mask;
  logic                 err;

  modport master (
    output bar_valid, bar_wid, bar_id, bar_size_m1,
    output flush_valid, flush_wid,
    input  stall_mask, release_valid, release_id,
    input  release_mask, err
  );

  modport slave (
    input  bar_valid, bar_wid, bar_id, bar_size_m1,
    input  flush_valid, flush_wid,
    output stall_mask, release_valid, release_id,
    output release_mask, err
  );
endinterface

// File: rtl/vx_barrier_unit.sv
// Warp barrier tracker: collects arrivals per barrier ID, stalls, releases.
// Optional VX_BAR_PERF_EN adds a stalled-warp-cycle counter port.
module vx_barrier_unit #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  vx_barrier_if.slave  bus
`ifdef VX_BAR_PERF_EN
  ,
  output logic [31:0]  perf_stall_cycles
`endif
);
  localparam int NW_WIDTH =
    (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NB_WIDTH =
    (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
  localparam int CW = NW_WIDTH + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef logic [NUM_WARPS-1:0] wmask_t;
  typedef logic [CW-1:0]        cnt_t;

  wmask_t [NUM_BARRIERS-1:0] mask_q, mask_d;
  cnt_t   [NUM_BARRIERS-1:0] cnt_q, cnt_d;

  wmask_t               stall_q, stall_d;
  logic                 rel_v_q, rel_v_d;
  logic [NB_WIDTH-1:0]  rel_id_q, rel_id_d;
  wmask_t               rel_m_q, rel_m_d;
  logic                 err_q, err_d;

  logic   arr;
  wmask_t w_oh;
  cnt_t   size_c;

  always_comb begin
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    stall_d  = stall_q;
    rel_v_d  = 1'b0;
    rel_id_d = '0;
    rel_m_d  = '0;
    err_d    = err_q;
    w_oh     = '0;
    w_oh[bus.bar_wid] = 1'b1;
    size_c   = {1'b0, bus.bar_size_m1};
    // Same-warp flush beats its own arrival; the arrival is silently dropped.
    arr = bus.bar_valid &&
          !(bus.flush_valid && bus.flush_wid == bus.bar_wid);

    if (bus.flush_valid) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        if (mask_d[b][bus.flush_wid]) begin
          mask_d[b][bus.flush_wid] = 1'b0;
          cnt_d[b] = cnt_d[b] - ONE;
        end
      end
      stall_d[bus.flush_wid] = 1'b0;
    end

    if (arr) begin
      if (stall_q[bus.bar_wid] ||
          cnt_d[bus.bar_id] > size_c) begin
        err_d = 1'b1;
      end else if (cnt_d[bus.bar_id] == size_c) begin
        rel_v_d  = 1'b1;
        rel_id_d = bus.bar_id;
        rel_m_d  = mask_d[bus.bar_id] | w_oh;
        stall_d  = stall_d & ~rel_m_d;
        mask_d[bus.bar_id] = '0;
        cnt_d[bus.bar_id]  = '0;
      end else begin
        mask_d[bus.bar_id] = mask_d[bus.bar_id] | w_oh;
        cnt_d[bus.bar_id]  = cnt_d[bus.bar_id] + ONE;
        stall_d = stall_d | w_oh;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q   <= '0;
      cnt_q    <= '0;
      stall_q  <= '0;
      rel_v_q  <= 1'b0;
      rel_id_q <= '0;
      rel_m_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      rel_v_q  <= rel_v_d;
      rel_id_q <= rel_id_d;
      rel_m_q  <= rel_m_d;
      err_q    <= err_d;
    end
  end

  assign bus.stall_mask    = stall_q;
  assign bus.release_valid = rel_v_q;
  assign bus.release_id    = rel_id_q;
  assign bus.release_mask  = rel_m_q;
  assign bus.err           = err_q;

`ifdef VX_BAR_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perf_q <= '0;
    else perf_q <= perf_q + 32'($countones(stall_q));
  end

  assign perf_stall_cycles = perf_q;
`endif
endmodule

// File: tb/tb_vx_barrier_unit.sv
// Directed self-checking bench for vx_barrier_unit.
// Inputs change 1ns after posedge or on negedge; outputs sampled 1ns after posedge.
module tb_vx_barrier_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  vx_barrier_if #(.NUM_WARPS(4), .NUM_BARRIERS(4)) bus ();

`ifdef VX_BAR_PERF_EN
  logic [31:0] perf_stall_cycles;
`endif

  vx_barrier_unit #(.NUM_WARPS(4), .NUM_BARRIERS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
`ifdef VX_BAR_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [1:0] w,
                       input logic [1:0] id, input logic [1:0] sz,
                       input logic fv, input logic [1:0] fw);
    bus.bar_valid   = v;
    bus.bar_wid     = w;
    bus.bar_id      = id;
    bus.bar_size_m1 = sz;
    bus.flush_valid = fv;
    bus.flush_wid   = fw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.stall_mask !== 4'b0000 || bus.release_valid !== 1'b0 ||
        bus.release_id !== 2'd0 || bus.release_mask !== 4'b0000 ||
        bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got st=%b rv=%b rid=%0d rm=%b err=%b exp all 0",
               bus.stall_mask, bus.release_valid, bus.release_id,
               bus.release_mask, bus.err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_release();
    logic [3:0] exp_st [3];
    exp_st = '{4'b0001, 4'b0011, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'(i), 2'd1, 2'd2, 1'b0, 2'd0);
      tick();
      n_checks++;
      if (bus.stall_mask !== exp_st[i]) begin
        n_fail++;
        $display("FAIL rel_stall%0d got=%b exp=%b", i, bus.stall_mask, exp_st[i]);
      end
    end
    n_checks++;
    if (bus.release_valid !== 1'b1 || bus.release_id !== 2'd1 ||
        bus.release_mask !== 4'b0111) begin
      n_fail++;
      $display("FAIL rel_pulse got rv=%b rid=%0d rm=%b exp 1/1/0111",
               bus.release_valid, bus.release_id, bus.release_mask);
    end
    idle();
    tick();
    n_checks++;
    if (bus.release_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rel_single_pulse got=%b exp=0", bus.release_valid);
    end
  endtask

  task automatic test_size_one();
    drive(1'b1, 2'd3, 2'd0, 2'd0, 1'b0, 2'd0);
    tick();
    n_checks++;
    if (bus.release_valid !== 1'b1 || bus.release_id !== 2'd0 ||
        bus.release_mask !== 4'b1000 || bus.stall_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL size1 got rv=%b rid=%0d rm=%b st=%b exp 1/0/1000/0000",
               bus.release_valid, bus.release_id, bus.release_mask,
               bus.stall_mask);
    end
    idle();
  endtask

  task automatic test_errors();
    do_reset();
    drive(1'b1, 2'd1, 2'd2, 2'd3, 1'b0, 2'd0);
    tick();
    drive(1'b1, 2'd1, 2'd2, 2'd3, 1'b0, 2'd0);
    tick();
    n_checks++;
    if (bus.err !== 1'b1 || bus.stall_mask !== 4'b0010 ||
        bus.release_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_dup got err=%b st=%b rv=%b exp 1/0010/0",
               bus.err, bus.stall_mask, bus.release_valid);
    end
    // cnt[2] must still be 1: W0,W2 stall, W3 then releases all four.
    drive(1'b1, 2'd0, 2'd2, 2'd3, 1'b0, 2'd0);
    tick();
    drive(1'b1, 2'd2, 2'd2, 2'd3, 1'b0, 2'd0);
    tick();
    n_checks++;
    if (bus.stall_mask !== 4'b0111 || bus.release_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_cnt_kept got st=%b rv=%b exp 0111/0",
               bus.stall_mask, bus.release_valid);
    end
    drive(1'b1, 2'd3, 2'd2, 2'd3, 1'b0, 2'd0);
    tick();
    n_checks++;
    if (bus.release_valid !== 1'b1 || bus.release_mask !== 4'b1111 ||
        bus.release_id !== 2'd2 || bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_release got rv=%b rm=%b rid=%0d err=%b exp 1/1111/2/1",
               bus.release_valid, bus.release_mask, bus.release_id, bus.err);
    end
    do_reset();
    drive(1'b1, 2'd0, 2'd0, 2'd2, 1'b0, 2'd0);
    tick();
    drive(1'b1, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0);
    tick();
    n_checks++;
    if (bus.err !== 1'b1 || bus.stall_mask !== 4'b0001 ||
        bus.release_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_size got err=%b st=%b rv=%b exp 1/0001/0",
               bus.err, bus.stall_mask, bus.release_valid);
    end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 2'd0, 2'd3, 2'd2, 1'b0, 2'd0);
    tick();
    drive(1'b1, 2'd1, 2'd3, 2'd2, 1'b0, 2'd0);
    tick();
    drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd1);
    tick();
    n_checks++;
    if (bus.stall_mask !== 4'b0001 || bus.release_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall got st=%b rv=%b exp 0001/0",
               bus.stall_mask, bus.release_valid);
    end
    drive(1'b1, 2'd2, 2'd3, 2'd2, 1'b0, 2'd0);
    tick();
    n_checks++;
    if (bus.stall_mask !== 4'b0101 || bus.release_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_w2 got st=%b rv=%b exp 0101/0",
               bus.stall_mask, bus.release_valid);
    end
    drive(1'b1, 2'd3, 2'd3, 2'd2, 1'b0, 2'd0);
    tick();
    n_checks++;
    if (bus.release_valid !== 1'b1 || bus.release_mask !== 4'b1101 ||
        bus.release_id !== 2'd3 || bus.stall_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL flush_release got rv=%b rm=%b rid=%0d st=%b exp 1/1101/3/0000",
               bus.release_valid, bus.release_mask, bus.release_id,
               bus.stall_mask);
    end
    idle();
  endtask

  task automatic test_collide_and_reset();
    do_reset();
    drive(1'b1, 2'd2, 2'd0, 2'd1, 1'b1, 2'd2);
    tick();
    n_checks++;
    if (bus.stall_mask !== 4'b0000 || bus.err !== 1'b0 ||
        bus.release_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL same_wid got st=%b err=%b rv=%b exp 0000/0/0",
               bus.stall_mask, bus.err, bus.release_valid);
    end
    drive(1'b1, 2'd0, 2'd1, 2'd1, 1'b0, 2'd0);
    tick();
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.stall_mask !== 4'b0000 || bus.err !== 1'b0 ||
        bus.release_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got st=%b err=%b rv=%b exp 0000/0/0",
               bus.stall_mask, bus.err, bus.release_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 2'd1, 2'd1, 2'd1, 1'b0, 2'd0);
    tick();
    n_checks++;
    if (bus.stall_mask !== 4'b0010 || bus.release_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset got st=%b rv=%b exp 0010/0",
               bus.stall_mask, bus.release_valid);
    end
    drive(1'b1, 2'd2, 2'd1, 2'd1, 1'b1, 2'd1);
    tick();
    n_checks++;
    if (bus.stall_mask !== 4'b0100 || bus.release_valid !== 1'b0 ||
        bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL diff_wid got st=%b rv=%b err=%b exp 0100/0/0",
               bus.stall_mask, bus.release_valid, bus.err);
    end
    drive(1'b1, 2'd3, 2'd1, 2'd1, 1'b0, 2'd0);
    tick();
    n_checks++;
    if (bus.release_valid !== 1'b1 || bus.release_mask !== 4'b1100 ||
        bus.release_id !== 2'd1 || (bus.stall_mask & bus.release_mask) !== 4'b0) begin
      n_fail++;
      $display("FAIL diff_rel got rv=%b rm=%b rid=%0d st=%b exp 1/1100/1/0000",
               bus.release_valid, bus.release_mask, bus.release_id,
               bus.stall_mask);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 2'd0, 2'd2, 2'd0, 1'b0, 2'd0);
    tick();
    n_checks++;
    if (bus.release_valid !== 1'b1 || bus.release_id !== 2'd2 ||
        bus.release_mask !== 4'b0001) begin
      n_fail++;
      $display("FAIL b2b_first got rv=%b rid=%0d rm=%b exp 1/2/0001",
               bus.release_valid, bus.release_id, bus.release_mask);
    end
    drive(1'b1, 2'd1, 2'd3, 2'd0, 1'b0, 2'd0);
    tick();
    n_checks++;
    if (bus.release_valid !== 1'b1 || bus.release_id !== 2'd3 ||
        bus.release_mask !== 4'b0010) begin
      n_fail++;
      $display("FAIL b2b_second got rv=%b rid=%0d rm=%b exp 1/3/0010",
               bus.release_valid, bus.release_id, bus.release_mask);
    end
    idle();
    tick();
    n_checks++;
    if (bus.release_valid !== 1'b0 || bus.stall_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL b2b_idle got rv=%b st=%b exp 0/0000",
               bus.release_valid, bus.stall_mask);
    end
  endtask

`ifdef VX_BAR_PERF_EN
  task automatic test_perf();
    do_reset();
    n_checks++;
    if (perf_stall_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset got=%0d exp=0", perf_stall_cycles);
    end
    drive(1'b1, 2'd0, 2'd0, 2'd3, 1'b0, 2'd0);
    tick();
    drive(1'b1, 2'd1, 2'd0, 2'd3, 1'b0, 2'd0);
    tick();
    idle();
    // One warp stalled for one cycle already, then 2 warps x 10 cycles.
    repeat (10) tick();
    n_checks++;
    if (perf_stall_cycles !== 32'd21) begin
      n_fail++;
      $display("FAIL perf_count got=%0d exp=21", perf_stall_cycles);
    end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_release();
    test_size_one();
    test_errors();
    test_flush();
    test_collide_and_reset();
    test_back_to_back();
`ifdef VX_BAR_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
